// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between two buffered writers using round-robin arbitration.
// Define RFARB_FIXED_PRIO_EN to give writer 0 fixed priority instead. Also flags pending writes on both read ports.
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd1_pending,
    output logic              rd2_pending,
    output logic              rf_WR,
    output logic [ADDR_W-1:0] rf_seti,
    output logic [DATA_W-1:0] rf_Input,
    output logic              gnt_id
);
    localparam int NREG = 2 ** ADDR_W;

    logic              buf0_full;
    logic [ADDR_W-1:0] buf0_addr;
    logic [DATA_W-1:0] buf0_data;
    logic              buf1_full;
    logic [ADDR_W-1:0] buf1_addr;
    logic [DATA_W-1:0] buf1_data;
    logic              grant0;
    logic              grant1;
    logic [NREG-1:0]   pending;

    assign req0_ready = !buf0_full;
    assign req1_ready = !buf1_full;

`ifdef RFARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = buf0_full;
        grant1 = buf1_full && !buf0_full;
    end
`else
    typedef enum logic {PRIO0, PRIO1} rr_state_t;

    rr_state_t rr_state;
    rr_state_t rr_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_state <= PRIO0;
        end else begin
            rr_state <= rr_next;
        end
    end

    // An uncontested grant still hands preference to the idle side, bounding its wait.
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        rr_next = rr_state;
        if (buf0_full && buf1_full) begin
            if (rr_state == PRIO0) begin
                grant0  = 1'b1;
                rr_next = PRIO1;
            end else begin
                grant1  = 1'b1;
                rr_next = PRIO0;
            end
        end else if (buf0_full) begin
            grant0  = 1'b1;
            rr_next = PRIO1;
        end else if (buf1_full) begin
            grant1  = 1'b1;
            rr_next = PRIO0;
        end
    end
`endif

    // Accept and drain are exclusive since ready is simply the empty flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf0_full <= 1'b0;
            buf0_addr <= '0;
            buf0_data <= '0;
        end else if (req0_valid && !buf0_full) begin
            buf0_full <= 1'b1;
            buf0_addr <= req0_addr;
            buf0_data <= req0_data;
        end else if (grant0) begin
            buf0_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf1_full <= 1'b0;
            buf1_addr <= '0;
            buf1_data <= '0;
        end else if (req1_valid && !buf1_full) begin
            buf1_full <= 1'b1;
            buf1_addr <= req1_addr;
            buf1_data <= req1_data;
        end else if (grant1) begin
            buf1_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_WR    <= 1'b0;
            rf_seti  <= '0;
            rf_Input <= '0;
            gnt_id   <= 1'b0;
        end else begin
            rf_WR <= grant0 || grant1;
            if (grant0) begin
                rf_seti  <= buf0_addr;
                rf_Input <= buf0_data;
                gnt_id   <= 1'b0;
            end else if (grant1) begin
                rf_seti  <= buf1_addr;
                rf_Input <= buf1_data;
                gnt_id   <= 1'b1;
            end
        end
    end

    // A register stays pending until the cycle its write is presented to the register file ends.
    always_comb begin
        pending = '0;
        for (int i = 0; i < NREG; i++) begin
            pending[i] = (buf0_full && (buf0_addr == ADDR_W'(i))) ||
                         (buf1_full && (buf1_addr == ADDR_W'(i))) ||
                         (rf_WR && (rf_seti == ADDR_W'(i)));
        end
    end

    assign rd1_pending = pending[rd_addr1];
    assign rd2_pending = pending[rd_addr2];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: expected commits are queued at stimulus time
// and popped by a monitor whenever the arbiter drives rf_WR.
module tb_regfile_wr_arbiter;

    typedef struct {
        logic        gnt;
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [2:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic        rd1_pending;
    logic        rd2_pending;
    logic        rf_WR;
    logic [2:0]  rf_seti;
    logic [31:0] rf_Input;
    logic        gnt_id;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mirror [8];
    logic        written [8];

    regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd1_pending(rd1_pending), .rd2_pending(rd2_pending),
        .rf_WR(rf_WR), .rf_seti(rf_seti), .rf_Input(rf_Input), .gnt_id(gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Commit monitor: what the register file would write on the next rising edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && rf_WR === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write actual seti=%0d Input=%0d gnt=%0d required none",
                         rf_seti, rf_Input, gnt_id);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_seti !== mon_e.addr || rf_Input !== mon_e.data || gnt_id !== mon_e.gnt) begin
                    errors++;
                    $display("[TB] FAIL commit_order actual seti=%0d Input=%0d gnt=%0d required seti=%0d Input=%0d gnt=%0d",
                             rf_seti, rf_Input, gnt_id, mon_e.addr, mon_e.data, mon_e.gnt);
                end
            end
            mirror[rf_seti]  = rf_Input;
            written[rf_seti] = 1'b1;
        end
    end

    task automatic push_exp(input logic g, input logic [2:0] a, input logic [31:0] d);
        exp_t e;
        e.gnt  = g;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send0(input logic [2:0] a, input logic [31:0] d);
        bit ok;
        int n;
        req0_valid = 1'b1;
        req0_addr  = a;
        req0_data  = d;
        n = 0;
        do begin
            ok = req0_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 20);
        req0_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL send0_accept actual=no_accept required=accept within 20 cycles");
        end
    endtask

    task automatic send1(input logic [2:0] a, input logic [31:0] d);
        bit ok;
        int n;
        req1_valid = 1'b1;
        req1_addr  = a;
        req1_data  = d;
        n = 0;
        do begin
            ok = req1_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 20);
        req1_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL send1_accept actual=no_accept required=accept within 20 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #2;
        checks += 6;
        if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready0 actual=%b required=1", req0_ready); end
        if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready1 actual=%b required=1", req1_ready); end
        if (rf_WR !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr actual=%b required=0", rf_WR); end
        if (rf_seti !== 3'd0) begin errors++; $display("[TB] FAIL reset_seti actual=%0d required=0", rf_seti); end
        if (rf_Input !== 32'd0) begin errors++; $display("[TB] FAIL reset_input actual=%0d required=0", rf_Input); end
        if (gnt_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt actual=%b required=0", gnt_id); end
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_single_write;
        rd_addr1 = 3'd2;
        rd_addr2 = 3'd2;
        push_exp(1'b0, 3'd2, 32'd567);
        send0(3'd2, 32'd567);
        checks += 3;
        if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_busy actual=%b required=0", req0_ready); end
        if (rf_WR !== 1'b0) begin errors++; $display("[TB] FAIL single_early_wr actual=%b required=0", rf_WR); end
        if (rd1_pending !== 1'b1) begin errors++; $display("[TB] FAIL single_pend_buf actual=%b required=1", rd1_pending); end
        @(posedge clk); #1;
        checks += 6;
        if (rf_WR !== 1'b1) begin errors++; $display("[TB] FAIL single_wr actual=%b required=1", rf_WR); end
        if (rf_seti !== 3'd2) begin errors++; $display("[TB] FAIL single_seti actual=%0d required=2", rf_seti); end
        if (rf_Input !== 32'd567) begin errors++; $display("[TB] FAIL single_input actual=%0d required=567", rf_Input); end
        if (gnt_id !== 1'b0) begin errors++; $display("[TB] FAIL single_gnt actual=%b required=0", gnt_id); end
        if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_drained actual=%b required=1", req0_ready); end
        if (rd2_pending !== 1'b1) begin errors++; $display("[TB] FAIL single_pend_rf actual=%b required=1", rd2_pending); end
        @(posedge clk); #1;
        checks += 4;
        if (rf_WR !== 1'b0) begin errors++; $display("[TB] FAIL single_wr_drop actual=%b required=0", rf_WR); end
        if (rf_seti !== 3'd2) begin errors++; $display("[TB] FAIL single_seti_hold actual=%0d required=2", rf_seti); end
        if (rf_Input !== 32'd567) begin errors++; $display("[TB] FAIL single_input_hold actual=%0d required=567", rf_Input); end
        if (rd1_pending !== 1'b0) begin errors++; $display("[TB] FAIL single_pend_clear actual=%b required=0", rd1_pending); end
        rd_addr2 = 3'd7;
        idle(1);
    endtask

    task automatic test_reset_mid_transfer;
        send0(3'd3, 32'd5);
        @(posedge clk); #1;
        checks++;
        if (rf_WR !== 1'b1) begin errors++; $display("[TB] FAIL midrst_inflight actual=%b required=1", rf_WR); end
        #1;
        reset = 1'b0;
        #1;
        checks += 4;
        if (rf_WR !== 1'b0) begin errors++; $display("[TB] FAIL midrst_wr actual=%b required=0", rf_WR); end
        if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready actual=%b required=1", req0_ready); end
        if (rf_seti !== 3'd0) begin errors++; $display("[TB] FAIL midrst_seti actual=%0d required=0", rf_seti); end
        if (rf_Input !== 32'd0) begin errors++; $display("[TB] FAIL midrst_input actual=%0d required=0", rf_Input); end
        @(posedge clk); #1;
        reset = 1'b1;
        idle(3);
        checks += 2;
        if (rf_WR !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_replay actual=%b required=0", rf_WR); end
        if (written[3] !== 1'b0) begin errors++; $display("[TB] FAIL midrst_r3_written actual=%b required=0", written[3]); end
    endtask

    task automatic test_contested;
        push_exp(1'b0, 3'd1, 32'd10);
        push_exp(1'b1, 3'd4, 32'd20);
        fork
            send0(3'd1, 32'd10);
            send1(3'd4, 32'd20);
        join
        @(posedge clk); #1;
        checks += 2;
        if (rf_WR !== 1'b1 || gnt_id !== 1'b0) begin errors++; $display("[TB] FAIL contest_first actual wr=%b gnt=%b required wr=1 gnt=0", rf_WR, gnt_id); end
        if (rf_seti !== 3'd1) begin errors++; $display("[TB] FAIL contest_first_seti actual=%0d required=1", rf_seti); end
        @(posedge clk); #1;
        checks += 2;
        if (rf_WR !== 1'b1 || gnt_id !== 1'b1) begin errors++; $display("[TB] FAIL contest_second actual wr=%b gnt=%b required wr=1 gnt=1", rf_WR, gnt_id); end
        if (rf_seti !== 3'd4) begin errors++; $display("[TB] FAIL contest_second_seti actual=%0d required=4", rf_seti); end
        idle(2);
    endtask

    task automatic test_same_address;
        rd_addr1 = 3'd5;
        #1;
        checks++;
        if (rd1_pending !== 1'b0) begin errors++; $display("[TB] FAIL same_pend_before actual=%b required=0", rd1_pending); end
        push_exp(1'b0, 3'd5, 32'd11);
        push_exp(1'b1, 3'd5, 32'd22);
        fork
            send0(3'd5, 32'd11);
            send1(3'd5, 32'd22);
        join
        checks++;
        if (rd1_pending !== 1'b1) begin errors++; $display("[TB] FAIL same_pend_buf actual=%b required=1", rd1_pending); end
        @(posedge clk); #1;
        checks++;
        if (rd1_pending !== 1'b1) begin errors++; $display("[TB] FAIL same_pend_first actual=%b required=1", rd1_pending); end
        @(posedge clk); #1;
        checks += 2;
        if (rd1_pending !== 1'b1) begin errors++; $display("[TB] FAIL same_pend_second actual=%b required=1", rd1_pending); end
        if (rf_Input !== 32'd22) begin errors++; $display("[TB] FAIL same_second_data actual=%0d required=22", rf_Input); end
        @(posedge clk); #1;
        checks += 2;
        if (rd1_pending !== 1'b0) begin errors++; $display("[TB] FAIL same_pend_clear actual=%b required=0", rd1_pending); end
        if (mirror[5] !== 32'd22) begin errors++; $display("[TB] FAIL same_final_r5 actual=%0d required=22", mirror[5]); end
        idle(1);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 4; k++) begin
            push_exp(1'b0, 3'd1, 32'h100 + k);
            push_exp(1'b1, 3'd6, 32'h200 + k);
        end
        fork
            for (int k = 0; k < 4; k++) send0(3'd1, 32'h100 + k);
            for (int k = 0; k < 4; k++) send1(3'd6, 32'h200 + k);
            begin
                int n;
                n = 0;
                while (rf_WR !== 1'b1 && n < 10) begin
                    @(posedge clk); #1;
                    n++;
                end
                for (int c = 0; c < 8; c++) begin
                    checks++;
                    if (rf_WR !== 1'b1 || gnt_id !== 1'(c % 2)) begin
                        errors++;
                        $display("[TB] FAIL b2b_grant%0d actual wr=%b gnt=%b required wr=1 gnt=%0d", c, rf_WR, gnt_id, c % 2);
                    end
                    @(posedge clk); #1;
                end
            end
        join
        idle(3);
    endtask

    task automatic test_no_hazard;
        rd_addr2 = 3'd7;
        push_exp(1'b0, 3'd0, 32'h0000_0AAA);
        push_exp(1'b1, 3'd6, 32'h0000_0BBB);
        push_exp(1'b0, 3'd0, 32'h0000_0CCC);
        push_exp(1'b1, 3'd6, 32'h0000_0DDD);
        fork
            begin
                send0(3'd0, 32'h0000_0AAA);
                send0(3'd0, 32'h0000_0CCC);
            end
            begin
                send1(3'd6, 32'h0000_0BBB);
                send1(3'd6, 32'h0000_0DDD);
            end
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (rd2_pending !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL nohaz_cycle%0d actual=%b required=0", c, rd2_pending);
                end
                @(posedge clk); #1;
            end
        join
        idle(3);
    endtask

    initial begin
        reset      = 1'b0;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = '0;
        rd_addr1   = '0;
        rd_addr2   = 3'd7;
        for (int i = 0; i < 8; i++) begin
            mirror[i]  = '0;
            written[i] = 1'b0;
        end

        test_reset();
        test_single_write();
        test_reset_mid_transfer();
        test_contested();
        test_same_address();
        test_back_to_back();
        test_no_hazard();

        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL sb_drained actual=%0d required=0", exp_q.size()); end
        if (written[7] !== 1'b0) begin errors++; $display("[TB] FAIL r7_untouched actual=%b required=0", written[7]); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
